ifetch_unit: RTL and testbench

- Instruction fetch stage that sits directly upstream of the single-cycle decode/execute core.
- Owns the fetch PC and issues 32-bit word reads to instruction memory over a req/ack handshake, with one request outstanding at a time.
- Fetched words are buffered in a small prefetch FIFO and presented to decode with a valid/ready handshake.
- Supports a redirect (branch/jump/reset vector), which flushes buffered instructions and discards any in-flight response.

---
 rtl/ifetch_pkg.sv | 22 ++
 rtl/ifetch_unit_fifo.sv | 70 +++++++
 rtl/ifetch_unit.sv | 157 +++++++++++++++
 tb/tb_ifetch_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch stage and its consumers.
// Holds the fetch FSM encoding, word geometry and opcode constants used by decode.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    // Opcode field values shared with the decode/execute core.
    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;

endpackage

// File: rtl/ifetch_unit_fifo.sv
// Prefetch FIFO of {instruction, pc} pairs between instruction memory and decode.
// Flush has priority over push and pop; the head is presented combinationally from storage.
module prefetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic [ADDR_W-1:0]  push_pc,
    input  logic               pop,
    output logic [CNT_W-1:0]   count,
    output logic               head_valid,
    output logic [INSTR_W-1:0] head_instr,
    output logic [ADDR_W-1:0]  head_pc
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0]  pc_mem    [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic               do_push;
    logic               do_pop;

    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign do_pop  = pop && (count != '0) && !flush;
    assign do_push = push && ((count != DEPTH_C) || do_pop) && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (do_push) begin
            instr_mem[wr_ptr] <= push_instr;
            pc_mem[wr_ptr]    <= push_pc;
        end
    end

    assign head_valid = (count != '0);
    assign head_instr = instr_mem[rd_ptr];
    assign head_pc    = pc_mem[rd_ptr];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one outstanding memory read at a
// time, buffers returned words in a prefetch FIFO and handles redirects with discard.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc
);

    localparam int               CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(3);
    endfunction

    // Handshakes: a memory read completes on the edge where mem_req && mem_ack; mem_req
    // and mem_addr hold until then. A decode transfer happens on the edge where
    // instr_valid && instr_ready. Neither side may retract a request once raised.

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] fetch_pc_next;
    logic              mem_req_next;
    logic [ADDR_W-1:0] mem_addr_next;
    logic [ADDR_W-1:0] redirect_al;
    logic [ADDR_W-1:0] issue_addr;
    logic              do_issue;
    logic              go_idle;
    logic              ack;
    logic              pop;
    logic              push;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_after_pop;
    logic              room_idle;
    logic              room_wait;

    assign redirect_al     = word_align(redirect_pc);
    assign ack             = mem_req && mem_ack;
    assign pop             = instr_valid && instr_ready && !redirect;
    assign push            = (state == WAIT) && ack && !redirect;
    assign count_after_pop = count - CNT_W'(pop);
    // The guard counts the request about to be issued, so its later push always fits.
    assign room_idle       = count_after_pop < DEPTH_C;
    assign room_wait       = (count_after_pop + CNT_W'(1)) < DEPTH_C;

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        mem_req_next  = mem_req;
        mem_addr_next = mem_addr;
        do_issue      = 1'b0;
        go_idle       = 1'b0;
        issue_addr    = fetch_pc;

        case (state)
            IDLE: begin
                if (redirect) begin
                    do_issue   = 1'b1;
                    issue_addr = redirect_al;
                end else if (room_idle) begin
                    do_issue = 1'b1;
                end
            end
            WAIT: begin
                if (ack) begin
                    if (redirect) begin
                        do_issue   = 1'b1;
                        issue_addr = redirect_al;
                    end else if (room_wait) begin
                        do_issue = 1'b1;
                    end else begin
                        go_idle = 1'b1;
                    end
                end else if (redirect) begin
                    // In-flight request cannot be aborted; its response gets dropped.
                    state_next    = DISCARD;
                    fetch_pc_next = redirect_al;
                end
            end
            DISCARD: begin
                if (ack) begin
                    if (redirect) begin
                        do_issue   = 1'b1;
                        issue_addr = redirect_al;
                    end else if (room_idle) begin
                        do_issue = 1'b1;
                    end else begin
                        go_idle = 1'b1;
                    end
                end else if (redirect) begin
                    fetch_pc_next = redirect_al;
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase

        if (do_issue) begin
            mem_req_next  = 1'b1;
            mem_addr_next = issue_addr;
            fetch_pc_next = issue_addr + ADDR_W'(PC_STEP);
            state_next    = WAIT;
        end else if (go_idle) begin
            mem_req_next = 1'b0;
            state_next   = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= word_align(RESET_PC);
            mem_req  <= 1'b0;
            mem_addr <= word_align(RESET_PC);
        end else begin
            state    <= state_next;
            fetch_pc <= word_align(fetch_pc_next);
            mem_req  <= mem_req_next;
            mem_addr <= mem_addr_next;
        end
    end

    prefetch_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect),
        .push       (push),
        .push_instr (mem_rdata),
        .push_pc    (mem_addr),
        .pop        (pop),
        .count      (count),
        .head_valid (instr_valid),
        .head_instr (instr),
        .head_pc    (instr_pc)
    );

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: streaming, fill/backpressure, redirect with discard,
// redirect coinciding with ack and pop, PC wrap from a high reset vector, reset mid-request.
module tb_ifetch_unit;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    logic        hi_redirect;
    logic [31:0] hi_redirect_pc;
    logic        hi_mem_req;
    logic [31:0] hi_mem_addr;
    logic        hi_mem_ack;
    logic [31:0] hi_mem_rdata;
    logic        hi_instr_valid;
    logic        hi_instr_ready;
    logic [31:0] hi_instr;
    logic [31:0] hi_instr_pc;

    int          checks;
    int          failures;
    logic [31:0] exp_q[$];

    ifetch_unit #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc)
    );

    ifetch_unit #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
        .clk         (clk),
        .rst         (rst),
        .redirect    (hi_redirect),
        .redirect_pc (hi_redirect_pc),
        .mem_req     (hi_mem_req),
        .mem_addr    (hi_mem_addr),
        .mem_ack     (hi_mem_ack),
        .mem_rdata   (hi_mem_rdata),
        .instr_valid (hi_instr_valid),
        .instr_ready (hi_instr_ready),
        .instr       (hi_instr),
        .instr_pc    (hi_instr_pc)
    );

    // Clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a few hand-chosen words, otherwise {addr[15:0], 16'hC0DE}.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0005;
            32'h0000_0004: return 32'h0201_0002;
            32'h0000_0008: return 32'h0302_0001;
            32'h0000_000C: return 32'h0403_0002;
            default:       return {a[15:0], 16'hC0DE};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Driver tasks: advance one edge, then settle before sampling and driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ack(input logic a, input logic [31:0] data);
        mem_ack   = a;
        mem_rdata = data;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect       = 1'b0;
        redirect_pc    = '0;
        mem_ack        = 1'b0;
        mem_rdata      = '0;
        instr_ready    = 1'b0;
        hi_redirect    = 1'b0;
        hi_redirect_pc = '0;
        hi_mem_ack     = 1'b0;
        hi_mem_rdata   = '0;
        hi_instr_ready = 1'b0;
        step();
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Reset state
        do_reset();
        check("rst_req",   {31'd0, mem_req},     32'd0);
        check("rst_addr",  mem_addr,             32'h0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr,                32'h0);
        check("rst_pc",    instr_pc,             32'h0);
        check("hi_rst_addr", hi_mem_addr,        32'hFFFF_FFF8);

        // Streaming with zero-wait ack and decode always ready
        rst = 1'b0;
        instr_ready = 1'b1;
        step();
        check("s1_req0",  {31'd0, mem_req}, 32'd1);
        check("s1_addr0", mem_addr, 32'h0);
        drive_ack(1'b1, word_at(mem_addr));
        step();
        check("s1_addr1", mem_addr, 32'h4);
        check("s1_valid", {31'd0, instr_valid}, 32'd1);
        check("s1_pc0",   instr_pc, 32'h0);
        check("s1_ins0",  instr, 32'h0000_0005);
        drive_ack(1'b1, word_at(mem_addr));
        step();
        check("s1_addr2", mem_addr, 32'h8);
        check("s1_pc1",   instr_pc, 32'h4);
        check("s1_ins1",  instr, 32'h0201_0002);
        drive_ack(1'b1, word_at(mem_addr));
        step();
        check("s1_addr3", mem_addr, 32'hC);
        check("s1_pc2",   instr_pc, 32'h8);
        check("s1_ins2",  instr, 32'h0302_0001);

        // Fill under backpressure: exactly four pushes, then request stops
        do_reset();
        rst = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            drive_ack(1'b1, word_at(mem_addr));
            step();
        end
        check("s2_req_full", {31'd0, mem_req}, 32'd0);
        check("s2_head_pc",  instr_pc, 32'h0);
        drive_ack(1'b0, '0);
        step();
        check("s2_req_hold", {31'd0, mem_req}, 32'd0);
        instr_ready = 1'b1;
        step();
        check("s2_req_pop",  {31'd0, mem_req}, 32'd1);
        check("s2_addr_pop", mem_addr, 32'h10);
        check("s2_pc_pop",   instr_pc, 32'h4);
        instr_ready = 1'b0;
        drive_ack(1'b1, word_at(mem_addr));
        step();
        check("s2_req_refull", {31'd0, mem_req}, 32'd0);
        drive_ack(1'b0, '0);
        exp_q = '{32'h4, 32'h8, 32'hC, 32'h10};
        instr_ready = 1'b1;
        while (exp_q.size() != 0) begin
            check("s2_drain_valid", {31'd0, instr_valid}, 32'd1);
            check("s2_drain_pc", instr_pc, exp_q.pop_front());
            step();
        end
        check("s2_drain_empty", {31'd0, instr_valid}, 32'd0);

        // Redirect while a request is waiting; its late response is dropped
        do_reset();
        rst = 1'b0;
        instr_ready = 1'b1;
        step();
        drive_ack(1'b1, word_at(mem_addr));
        step();
        drive_ack(1'b1, word_at(mem_addr));
        step();
        check("s3_addr_wait", mem_addr, 32'h8);
        drive_ack(1'b0, '0);
        redirect = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        check("s3_req_held",  {31'd0, mem_req}, 32'd1);
        check("s3_addr_held", mem_addr, 32'h8);
        check("s3_flushed",   {31'd0, instr_valid}, 32'd0);
        step();
        step();
        check("s3_addr_held2", mem_addr, 32'h8);
        drive_ack(1'b1, 32'hDEAD_BEEF);
        step();
        check("s3_addr_redir", mem_addr, 32'h40);
        check("s3_dropped",    {31'd0, instr_valid}, 32'd0);
        drive_ack(1'b1, word_at(mem_addr));
        step();
        check("s3_pc_first", instr_pc, 32'h40);
        check("s3_ins_first", instr, 32'h0040_C0DE);

        // Redirect coinciding with ack and pop: flush wins, no push
        check("s4_addr_pre", mem_addr, 32'h44);
        drive_ack(1'b1, word_at(mem_addr));
        redirect = 1'b1;
        redirect_pc = 32'h80;
        step();
        redirect = 1'b0;
        drive_ack(1'b0, '0);
        check("s4_addr_redir", mem_addr, 32'h80);
        check("s4_valid0", {31'd0, instr_valid}, 32'd0);
        step();
        check("s4_valid1", {31'd0, instr_valid}, 32'd0);

        // High reset vector wraps modulo 2^32
        do_reset();
        rst = 1'b0;
        hi_instr_ready = 1'b1;
        step();
        check("s5_addr0", hi_mem_addr, 32'hFFFF_FFF8);
        hi_mem_ack = 1'b1;
        hi_mem_rdata = 32'h1111_0001;
        step();
        check("s5_addr1", hi_mem_addr, 32'hFFFF_FFFC);
        check("s5_pc0",   hi_instr_pc, 32'hFFFF_FFF8);
        hi_mem_rdata = 32'h1111_0002;
        step();
        check("s5_addr2", hi_mem_addr, 32'h0000_0000);
        check("s5_pc1",   hi_instr_pc, 32'hFFFF_FFFC);
        check("s5_ins1",  hi_instr, 32'h1111_0002);
        hi_mem_ack = 1'b0;

        // Reset mid-request, then a stray ack while mem_req is low
        do_reset();
        rst = 1'b0;
        step();
        check("s6_req_pre", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        step();
        check("s6_req_rst",   {31'd0, mem_req}, 32'd0);
        check("s6_valid_rst", {31'd0, instr_valid}, 32'd0);
        rst = 1'b0;
        drive_ack(1'b1, 32'hBAD0_BAD0);
        step();
        drive_ack(1'b0, '0);
        check("s6_req_post",   {31'd0, mem_req}, 32'd1);
        check("s6_addr_post",  mem_addr, 32'h0);
        check("s6_valid_post", {31'd0, instr_valid}, 32'd0);
        step();
        check("s6_valid_late", {31'd0, instr_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
